// File: rtl/fft_error_locator_scan_pkg.sv
// Shared decapsulation constants and GF(2^M) helpers for the error-locator scan
// and the additive-FFT address logic.
package fft_error_locator_scan_pkg;

  localparam int              DEFAULT_M        = 8;
  localparam logic [7:0]      DEFAULT_POLY_REV = 8'h71;

  // Number of Reed-Solomon codeword positions per security level.
  function automatic int n1_for_sec(input int sec);
    case (sec)
      192:     return 56;
      256:     return 90;
      default: return 46;
    endcase
  endfunction

  // Width that can hold any count from 0 to n1 inclusive.
  function automatic int ww_for(input int n1);
    return $clog2(n1 + 1);
  endfunction

  function automatic int beats_for(input int n1, input int lanes);
    return (n1 + lanes - 1) / lanes;
  endfunction

  // Multiply by alpha in the bit-reversed representation: shift towards the
  // MSB and fold the reduction polynomial back in when the top bit falls out.
  // Elements are carried in 16 bits so the FFT side can reuse this for any M.
  function automatic logic [15:0] gf_mul_alpha_rev(input logic [15:0] a,
                                                   input logic [15:0] poly_rev,
                                                   input int          m);
    logic [15:0] mask;
    logic [15:0] r;
    mask = 16'((32'd1 << m) - 32'd1);
    r    = (a << 1) & mask;
    if (((a >> (m - 1)) & 16'h0001) != 16'h0000) r = r ^ (poly_rev & mask);
    return r;
  endfunction

endpackage

// File: rtl/fft_pos_addr_gen.sv
// Codeword-position address generator: produces LANES consecutive field
// addresses per beat, starting at position 0 (address 0), then 1 << (M-1),
// then successive multiplications by alpha.
module fft_pos_addr_gen
  import fft_error_locator_scan_pkg::*;
#(
  parameter int             M        = DEFAULT_M,
  parameter logic [M-1:0]   POLY_REV = M'(DEFAULT_POLY_REV),
  parameter int             LANES    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [LANES*M-1:0] addr_o
);

  localparam logic [M-1:0] POS_ONE = {1'b1, {(M-1){1'b0}}};

  // Position 0 maps to the zero element, which alpha cannot reach, so the
  // step out of zero is special-cased to the field's unit element.
  function automatic logic [M-1:0] step(input logic [M-1:0] x);
    if (x == '0) return POS_ONE;
    return M'(gf_mul_alpha_rev(16'(x), 16'(POLY_REV), M));
  endfunction

  logic [M-1:0] pos_q, pos_d;
  logic [M-1:0] lane_addr [LANES];

  // Chain of multiply-by-alpha stages giving every lane of the current beat.
  always_comb begin
    addr_o = '0;
    lane_addr[0] = pos_q;
    for (int j = 1; j < LANES; j++) lane_addr[j] = step(lane_addr[j-1]);
    for (int j = 0; j < LANES; j++) addr_o[j*M +: M] = lane_addr[j];
  end

  // Clear rewinds to position 0; advance jumps LANES positions ahead.
  always_comb begin
    pos_d = pos_q;
    if (clear_i)        pos_d = '0;
    else if (advance_i) pos_d = step(lane_addr[LANES-1]);
  end

  // Position register.
  always_ff @(posedge clk_i) begin
    if (rst_i) pos_q <= '0;
    else       pos_q <= pos_d;
  end

endmodule

// File: rtl/fft_error_locator_scan.sv
// Error-locator scan: reads ELP evaluations from the FFT output RAM in
// codeword-position order, builds the error-position vector and weight, and
// holds the result until the consumer takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_READ  | one RAM strobe per beat, BEATS beats
// ST_DRAIN | waiting RAM_LAT cycles for the last beat to be captured
// ST_DONE  | result valid, waiting for dout_ready_i
module fft_error_locator_scan
  import fft_error_locator_scan_pkg::*;
#(
  parameter int                 PARAM_SECURITY = 128,
  parameter int                 PARAM_N1       = n1_for_sec(PARAM_SECURITY),
  parameter int                 PARAM_M        = DEFAULT_M,
  parameter logic [PARAM_M-1:0] POLY_REV       = PARAM_M'(DEFAULT_POLY_REV),
  parameter int                 IN_DW          = 8,
  parameter int                 LANES          = 1,
  parameter int                 RAM_LAT        = 1,
  localparam int                WW             = ww_for(PARAM_N1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WW-1:0]            elp_deg_i,
  output logic                     busy_o,
  output logic                     ram_rd_o,
  output logic [LANES*PARAM_M-1:0] ram_addr_o,
  input  logic [LANES*IN_DW-1:0]   ram_din_i,
  output logic [PARAM_N1-1:0]      dout_o,
  output logic [WW-1:0]            weight_o,
  output logic                     fail_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i
);

  localparam int BEATS      = beats_for(PARAM_N1, LANES);
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW         = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int LAST_LANES = PARAM_N1 - (BEATS - 1) * LANES;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [PARAM_N1-1:0] dout_q, dout_d;
  logic [WW-1:0]       weight_q, weight_d;
  logic [WW-1:0]       elp_deg_q, elp_deg_d;
  logic [RAM_LAT-1:0]  cap_vld_q, cap_vld_d;
  logic [BW-1:0]       cap_beat_q [RAM_LAT];
  logic [BW-1:0]       cap_beat_d [RAM_LAT];

  logic                     start_acc;
  logic                     rd;
  logic                     last_beat;
  logic                     cap_en;
  logic [BW-1:0]            cap_beat;
  logic [LANES*PARAM_M-1:0] gen_addr;
  logic [LANES-1:0]         lane_zero;
  logic [LANES-1:0]         lane_ok;
  logic [WW-1:0]            hit_cnt;

  assign rd        = (state_q == ST_READ);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign cap_en    = cap_vld_q[RAM_LAT-1];
  assign cap_beat  = cap_beat_q[RAM_LAT-1];

  fft_pos_addr_gen #(
    .M        (PARAM_M),
    .POLY_REV (POLY_REV),
    .LANES    (LANES)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (start_acc),
    .advance_i (rd),
    .addr_o    (gen_addr)
  );

  // Sequencing: start acceptance, beat counting and the drain down-counter.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    elp_deg_d = elp_deg_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_READ;
          beat_d    = '0;
          elp_deg_d = elp_deg_i;
        end
      end
      ST_READ: begin
        if (last_beat) begin
          state_d = ST_DRAIN;
          drain_d = DW'(RAM_LAT - 1);
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      ST_DONE: begin
        if (dout_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lanes past the last codeword position are parked at address 0.
  always_comb begin
    ram_addr_o = '0;
    for (int j = 0; j < LANES; j++) begin
      if (rd && !(last_beat && (j >= LAST_LANES)))
        ram_addr_o[j*PARAM_M +: PARAM_M] = gen_addr[j*PARAM_M +: PARAM_M];
    end
  end

  // Beat index travels with the strobe so capture does not depend on state.
  always_comb begin
    cap_vld_d     = '0;
    cap_vld_d[0]  = rd;
    cap_beat_d[0] = beat_q;
    for (int k = 1; k < RAM_LAT; k++) begin
      cap_vld_d[k]  = cap_vld_q[k-1];
      cap_beat_d[k] = cap_beat_q[k-1];
    end
  end

  // Capture: each lane writes its own position bit; weight adds valid hits.
  always_comb begin
    dout_d   = dout_q;
    weight_d = weight_q;
    hit_cnt  = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_zero[j] = (ram_din_i[j*IN_DW +: IN_DW] == '0);
      lane_ok[j]   = (cap_beat != BW'(BEATS - 1)) || (j < LAST_LANES);
      hit_cnt      = hit_cnt + WW'(lane_zero[j] & lane_ok[j]);
    end
    if (start_acc) begin
      dout_d   = '0;
      weight_d = '0;
    end else if (cap_en) begin
      weight_d = weight_q + hit_cnt;
      for (int i = 0; i < PARAM_N1; i++) begin
        if (cap_beat == BW'(i / LANES)) dout_d[i] = lane_zero[i % LANES];
      end
    end
  end

  // State registers; reset also drops any capture still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      drain_q   <= '0;
      dout_q    <= '0;
      weight_q  <= '0;
      elp_deg_q <= '0;
      cap_vld_q <= '0;
      for (int k = 0; k < RAM_LAT; k++) cap_beat_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      dout_q     <= dout_d;
      weight_q   <= weight_d;
      elp_deg_q  <= elp_deg_d;
      cap_vld_q  <= cap_vld_d;
      cap_beat_q <= cap_beat_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign ram_rd_o     = rd;
  assign dout_o       = dout_q;
  assign weight_o     = weight_q;
  assign fail_o       = (weight_q != elp_deg_q);
  assign dout_valid_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_error_locator_scan.sv
// Directed bench for the error-locator scan: one instance with LANES=1,
// RAM_LAT=1, N1=46 and one with LANES=4, RAM_LAT=2, N1=90.
module tb_fft_error_locator_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, busy_a, rd_a, vld_a, ready_a, fail_a;
  logic [5:0]  elp_a, weight_a;
  logic [7:0]  addr_a, din_a;
  logic [45:0] dout_a;

  logic        start_b, busy_b, rd_b, vld_b, ready_b, fail_b;
  logic [6:0]  elp_b, weight_b;
  logic [31:0] addr_b, din_b;
  logic [89:0] dout_b;

  int mode_a, mode_b;
  logic [7:0]  a_d1;
  logic [31:0] b_d1, b_d2;

  int err_cnt = 0;
  int chk_cnt = 0;

  int          a_strobes, a_vcyc, a_busy1;
  logic [7:0]  a_addr [5];
  int          b_strobes, b_vcyc;
  logic [31:0] b_first, b_last;

  fft_error_locator_scan #(.PARAM_SECURITY(128), .LANES(1), .RAM_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .elp_deg_i(elp_a),
    .busy_o(busy_a), .ram_rd_o(rd_a), .ram_addr_o(addr_a), .ram_din_i(din_a),
    .dout_o(dout_a), .weight_o(weight_a), .fail_o(fail_a),
    .dout_valid_o(vld_a), .dout_ready_i(ready_a));

  fft_error_locator_scan #(.PARAM_SECURITY(256), .LANES(4), .RAM_LAT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .elp_deg_i(elp_b),
    .busy_o(busy_b), .ram_rd_o(rd_b), .ram_addr_o(addr_b), .ram_din_i(din_b),
    .dout_o(dout_b), .weight_o(weight_b), .fail_o(fail_b),
    .dout_valid_o(vld_b), .dout_ready_i(ready_b));

  // RAM contents: 0 = never zero, 1 = zero at 128/27/232, 2 = all zero.
  function automatic logic [7:0] ram_word(input int mode, input logic [7:0] addr);
    case (mode)
      1:       return (addr == 8'd128 || addr == 8'd27 || addr == 8'd232) ? 8'h00 : 8'h5A;
      2:       return 8'h00;
      default: return {addr[7:1], 1'b1};
    endcase
  endfunction

  always @(posedge clk) begin
    a_d1 <= addr_a;
    b_d1 <= addr_b;
    b_d2 <= b_d1;
  end

  assign din_a = ram_word(mode_a, a_d1);
  always_comb begin
    din_b = '0;
    for (int j = 0; j < 4; j++) din_b[j*8 +: 8] = ram_word(mode_b, b_d2[j*8 +: 8]);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where dout_valid is first seen.
  task automatic scan_a(input logic [5:0] elp);
    start_a = 1'b1;
    elp_a   = elp;
    @(negedge clk);
    start_a   = 1'b0;
    a_strobes = 0;
    a_vcyc    = 0;
    a_busy1   = int'(busy_a);
    for (int cyc = 1; cyc <= 200 && a_vcyc == 0; cyc++) begin
      if (rd_a) begin
        if (a_strobes < 5) a_addr[a_strobes] = addr_a;
        a_strobes++;
      end
      if (vld_a) a_vcyc = cyc;
      else       @(negedge clk);
    end
    if (a_vcyc == 0) chk("a_timeout", 0, 1);
  endtask

  task automatic scan_b(input logic [6:0] elp);
    start_b = 1'b1;
    elp_b   = elp;
    @(negedge clk);
    start_b   = 1'b0;
    b_strobes = 0;
    b_vcyc    = 0;
    for (int cyc = 1; cyc <= 200 && b_vcyc == 0; cyc++) begin
      if (rd_b) begin
        if (b_strobes == 0) b_first = addr_b;
        b_last = addr_b;
        b_strobes++;
      end
      if (vld_b) b_vcyc = cyc;
      else       @(negedge clk);
    end
    if (b_vcyc == 0) chk("b_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    elp_a = '0; elp_b = '0; mode_a = 0; mode_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy_a", busy_a, 0);
    chk("rst_rd_a", rd_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_weight_a", weight_a, 0);
    chk("rst_fail_a", fail_a, 0);
    chk("rst_vld_a", vld_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_vld_b", vld_b, 0);

    // Address sequence, all-nonzero RAM, elp_deg=3
    mode_a = 0;
    scan_a(6'd3);
    chk("seq_busy1", a_busy1, 1);
    chk("seq_addr0", a_addr[0], 8'd0);
    chk("seq_addr1", a_addr[1], 8'd128);
    chk("seq_addr2", a_addr[2], 8'd113);
    chk("seq_addr3", a_addr[3], 8'd226);
    chk("seq_addr4", a_addr[4], 8'd181);
    chk("seq_strobes", a_strobes, 46);
    chk("seq_valid_cyc", a_vcyc, 48);
    chk("seq_dout", dout_a, 0);
    chk("seq_weight", weight_a, 0);
    chk("seq_fail", fail_a, 1);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("seq_vld_after_hs", vld_a, 0);

    // Zero positions 1 and 5, elp_deg=2
    mode_a = 1;
    scan_a(6'd2);
    chk("zero_valid_cyc", a_vcyc, 48);
    chk("zero_dout", dout_a, 46'h22);
    chk("zero_weight", weight_a, 2);
    chk("zero_fail", fail_a, 0);

    // Back-pressure with ignored start pulses
    for (int k = 0; k < 10; k++) begin
      start_a = (k == 3 || k == 6);
      @(negedge clk);
      chk("bp_vld", vld_a, 1);
      chk("bp_dout", dout_a, 46'h22);
      chk("bp_rd", rd_a, 0);
    end
    start_a = 1'b0;
    chk("bp_weight", weight_a, 2);
    chk("bp_fail", fail_a, 0);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("hs_vld", vld_a, 0);
    chk("hs_busy", busy_a, 0);
    chk("hs_dout_kept", dout_a, 46'h22);
    chk("hs_weight_kept", weight_a, 2);

    // Back-to-back: immediate start, all-nonzero RAM, elp_deg=0
    mode_a = 0;
    scan_a(6'd0);
    chk("b2b_busy1", a_busy1, 1);
    chk("b2b_valid_cyc", a_vcyc, 48);
    chk("b2b_dout", dout_a, 0);
    chk("b2b_weight", weight_a, 0);
    chk("b2b_fail", fail_a, 0);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;

    // Reset mid-scan at beat 20, all-zero RAM
    mode_a  = 2;
    start_a = 1'b1;
    elp_a   = 6'd5;
    @(negedge clk);
    start_a = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (rd_a && cnt == 20) break;
      if (rd_a) cnt++;
      @(negedge clk);
    end
    chk("mid_beat_reached", cnt, 20);
    chk("mid_dout_before", dout_a, 46'h7FFFF);
    chk("mid_weight_before", weight_a, 19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy_a, 0);
    chk("mid_rd", rd_a, 0);
    chk("mid_addr", addr_a, 0);
    chk("mid_dout", dout_a, 0);
    chk("mid_weight", weight_a, 0);
    chk("mid_fail", fail_a, 0);
    chk("mid_vld", vld_a, 0);
    repeat (4) @(negedge clk);
    chk("mid_dout_late", dout_a, 0);
    chk("mid_weight_late", weight_a, 0);
    mode_a = 1;
    scan_a(6'd2);
    chk("fresh_valid_cyc", a_vcyc, 48);
    chk("fresh_dout", dout_a, 46'h22);
    chk("fresh_weight", weight_a, 2);
    chk("fresh_fail", fail_a, 0);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;

    // Lane masking: LANES=4, N1=90, RAM_LAT=2, all-zero RAM
    mode_b = 2;
    scan_b(7'd90);
    chk("lane_strobes", b_strobes, 23);
    chk("lane_first_addr", b_first, 32'hE271_8000);
    chk("lane_last_hi", b_last[31:16], 0);
    chk("lane_valid_cyc", b_vcyc, 26);
    chk("lane_dout", dout_b, {90{1'b1}});
    chk("lane_weight", weight_b, 90);
    chk("lane_fail", fail_b, 0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    chk("lane_hs_vld", vld_b, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
